// File: rtl/nibble_serial_adder_seq.sv
// nibble_serial_adder_seq: WIDTH-bit add/subtract computed one nibble per clock
// through an external 4-bit ripple adder, LS nibble first, carry chained in a register.
module nibble_serial_adder_seq #(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned WIDTH   = 4 * NIBBLES,
  localparam int unsigned KW      = $clog2(NIBBLES)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  input  logic             In_Cin,
  input  logic             In_Sub,
  output logic [3:0]       Add_A,
  output logic [3:0]       Add_B,
  output logic             Add_Cin,
  input  logic [3:0]       Add_Y,
  input  logic             Add_Cout,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_Sum,
  output logic             Out_Cout,
  output logic             Out_Ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_next;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic             w_last;
  logic             w_ovf;

  assign w_last = (r_k == KW'(NIBBLES - 1));

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and state-decoded outputs; adder is fed only from registers
  always_comb begin
    w_state_next = r_state;
    In_Ready     = 1'b0;
    Out_Valid    = 1'b0;
    Add_A        = 4'd0;
    Add_B        = 4'd0;
    Add_Cin      = 1'b0;
    w_sum_next   = r_sum;
    w_ovf        = 1'b0;
    case (r_state)
      S_IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        Add_A   = r_op_a[{r_k, 2'b00} +: 4];
        Add_B   = r_op_b[{r_k, 2'b00} +: 4];
        Add_Cin = r_carry;
        w_sum_next[{r_k, 2'b00} +: 4] = Add_Y;
        w_ovf   = Add_Cout ^ (Add_A[3] ^ Add_B[3] ^ Add_Y[3]);
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, nibble stepping, carry chaining and result latch
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_sum    <= '0;
      r_k      <= '0;
      r_carry  <= 1'b0;
      Out_Sum  <= '0;
      Out_Cout <= 1'b0;
      Out_Ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (In_Valid) begin
            r_op_a  <= In_A;
            r_op_b  <= In_Sub ? ~In_B : In_B;
            r_carry <= In_Sub | In_Cin;
            r_k     <= '0;
            r_sum   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= Add_Cout;
          if (w_last) begin
            Out_Sum  <= w_sum_next;
            Out_Cout <= Add_Cout;
            Out_Ovf  <= w_ovf;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// tb_nibble_serial_adder_seq: directed vectors with a queued scoreboard and an
// independent output monitor; the 4-bit ripple adder is modelled behaviourally.
module tb_nibble_serial_adder_seq;

  logic        Clk;
  logic        Rst;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] In_A;
  logic [15:0] In_B;
  logic        In_Cin;
  logic        In_Sub;
  logic [3:0]  Add_A;
  logic [3:0]  Add_B;
  logic        Add_Cin;
  logic [3:0]  Add_Y;
  logic        Add_Cout;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Out_Sum;
  logic        Out_Cout;
  logic        Out_Ovf;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  nibble_serial_adder_seq #(.NIBBLES(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_A(In_A), .In_B(In_B), .In_Cin(In_Cin), .In_Sub(In_Sub),
    .Add_A(Add_A), .Add_B(Add_B), .Add_Cin(Add_Cin),
    .Add_Y(Add_Y), .Add_Cout(Add_Cout),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Sum(Out_Sum), .Out_Cout(Out_Cout), .Out_Ovf(Out_Ovf)
  );

  // Combinational 4-bit adder model
  assign {Add_Cout, Add_Y} = 5'(Add_A) + 5'(Add_B) + 5'(Add_Cin);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is checked against the queue head
  always @(negedge Clk) begin
    if (!Rst && Out_Valid && Out_Ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'(Out_Sum), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_sum",  32'(Out_Sum),  32'(e.sum));
        chk("out_cout", 32'(Out_Cout), 32'(e.cout));
        chk("out_ovf",  32'(Out_Ovf),  32'(e.ovf));
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input logic push, input exp_t e);
    int t;
    if (push) q.push_back(e);
    @(posedge Clk); #1;
    In_Valid = 1'b1; In_A = a; In_B = b; In_Cin = cin; In_Sub = sub;
    t = 0;
    do begin
      @(negedge Clk);
      t++;
    end while (!In_Ready && t < 50);
    if (!In_Ready) chk("accept_timeout", 32'(In_Ready), 32'd1);
    @(posedge Clk); #1;
    In_Valid = 1'b0;
  endtask

  // Called right after the accept edge: checks the chained carries and latency
  task automatic run_check(input string name, input logic [3:0] cins);
    for (int j = 0; j < 4; j++) begin
      @(negedge Clk);
      chk({name, "_add_cin"}, 32'(Add_Cin), 32'(cins[j]));
      chk({name, "_early_valid"}, 32'(Out_Valid), 32'd0);
    end
    @(negedge Clk);
    chk({name, "_latency"}, 32'(Out_Valid), 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (Out_Valid && t < 50) begin
      @(negedge Clk);
      t++;
    end
    if (Out_Valid) chk("drain_timeout", 32'(Out_Valid), 32'd0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!Out_Valid && t < 50) begin
      @(negedge Clk);
      t++;
    end
    if (!Out_Valid) chk("done_timeout", 32'(Out_Valid), 32'd1);
    drain();
  endtask

  initial begin
    int vcount;
    Rst = 1'b1; In_Valid = 1'b0; In_A = '0; In_B = '0; In_Cin = 1'b0; In_Sub = 1'b0;
    Out_Ready = 1'b1;
    #1;
    chk("rst_in_ready",  32'(In_Ready),  32'd1);
    chk("rst_out_valid", 32'(Out_Valid), 32'd0);
    chk("rst_out_sum",   32'(Out_Sum),   32'd0);
    chk("rst_add_cin",   32'(Add_Cin),   32'd0);
    @(negedge Clk); Rst = 1'b0;

    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, '{16'h5555, 1'b0, 1'b0});
    run_check("add1", 4'b0000); drain();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0});
    run_check("add2", 4'b1110); drain();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, '{16'h8000, 1'b0, 1'b1});
    run_check("add3", 4'b1110); drain();
    issue(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
    run_check("add4", 4'b0000); drain();
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
    run_check("sub1", 4'b0001); drain();
    issue(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, '{16'h0002, 1'b1, 1'b0});
    run_check("sub2", 4'b1111); drain();

    // Backpressure in DONE with a competing operand offer
    Out_Ready = 1'b0;
    issue(16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b1, '{16'h1000, 1'b0, 1'b0});
    run_check("bp", 4'b1110);
    q.push_back('{16'h0007, 1'b0, 1'b0});
    @(posedge Clk); #1;
    In_Valid = 1'b1; In_A = 16'h0003; In_B = 16'h0004; In_Cin = 1'b0; In_Sub = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge Clk);
      chk("bp_valid_held", 32'(Out_Valid), 32'd1);
      chk("bp_in_ready",   32'(In_Ready),  32'd0);
      chk("bp_sum_stable", 32'(Out_Sum),   32'h1000);
      @(posedge Clk); #1;
    end
    Out_Ready = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("bp_idle_ready", 32'(In_Ready), 32'd1);
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    @(negedge Clk);
    chk("bp_next_accepted", 32'(In_Ready), 32'd0);
    wait_done();

    // Reset in the middle of RUN (nibble index 2)
    issue(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, '{16'h0000, 1'b0, 1'b0});
    @(posedge Clk); @(posedge Clk); #2;
    Rst = 1'b1;
    #1;
    chk("mid_rst_in_ready",  32'(In_Ready),  32'd1);
    chk("mid_rst_out_valid", 32'(Out_Valid), 32'd0);
    chk("mid_rst_add_a",     32'(Add_A),     32'd0);
    chk("mid_rst_add_b",     32'(Add_B),     32'd0);
    chk("mid_rst_out_sum",   32'(Out_Sum),   32'd0);
    chk("mid_rst_out_cout",  32'(Out_Cout),  32'd0);
    @(negedge Clk); Rst = 1'b0;
    vcount = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge Clk);
      if (Out_Valid) vcount++;
    end
    chk("mid_rst_no_valid", 32'(vcount), 32'd0);
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, '{16'h0002, 1'b0, 1'b0});
    run_check("post_rst", 4'b0000); drain();

    @(negedge Clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
